addr_unit_ras: RTL and testbench
================================

Name: addr_unit_ras

Overview:
- Parametrised next-generation SAYEH addressing unit: program counter, address-generation logic and a hardware return-address stack (RAS) for call/return.
- Produces the memory address every cycle from PC, register operand (Rside) and immediate (Iside).
- Sits between the controller (mode strobes) and the memory address bus; replaces the fixed 16-bit PC/AddressLogic pair.

Parameters:
- AW, 16, address and PC width in bits.
- IW, 8, immediate width; extended to AW.
- SIGNED_IMM, 1, 1 = sign-extend Iside, 0 = zero-extend.
- DEPTH, 8, RAS entries; power of two, >= 2.
- DW, 4, depth counter width; must satisfy 2^DW > DEPTH (default holds 0..8).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- Rside  in  AW  register operand
- Iside  in  IW  immediate offset
- ResetPC  in  1  address = 0
- PCplusI  in  1  address = PC + ext(I)
- PCplus1  in  1  address = PC + 1
- RplusI  in  1  address = R + ext(I)
- Rplus0  in  1  address = R
- PCenable  in  1  PC loads Address; stack ops take effect only when high
- call  in  1  push PC+1 onto RAS
- ret  in  1  address = RAS top; pop
- clr_flags  in  1  clear sticky ovf/unf
- Address  out  AW  combinational address
- PCout  out  AW  current PC register
- depth  out  DW  valid RAS entries, 0..DEPTH
- stack_full  out  1  depth == DEPTH
- stack_empty  out  1  depth == 0
- ovf  out  1  sticky overflow flag
- unf  out  1  sticky underflow flag

Behaviour:
- Reset (synchronous, checked first): PC=0, depth=0, RAS pointer=0, ovf=unf=0. While reset is high, Address=0 and all stack/PC requests are ignored.
- Address is combinational, zero cycles latency. Mode priority: ResetPC > ret > Rplus0 > RplusI > PCplusI > PCplus1 > none. With no mode strobe, Address = PC.
- ret (stack non-empty): Address = top entry. ret with empty stack: Address = PC+1 and unf is set.
- All sums are modulo 2^AW and wrap silently, e.g. FFFF+1 = 0000 at AW=16. ext(I) follows SIGNED_IMM.
- PC register: on a clk edge with PCenable=1, PC <= Address. With PCenable=0, PC holds and call/ret/flag-setting are suppressed.
- Push value is always PC+1 (mod 2^AW), independent of the selected mode.
- call only: push at the edge; depth+1.
- ret only: pop at the edge; depth-1.
- call+ret together: top entry is overwritten with PC+1, depth unchanged, Address = old top. If the stack is empty in this case, it behaves as a plain push and unf is set.
- Full push (call while depth==DEPTH, no ret): set ovf. Behaviour per RAS_WRAP_EN.
- clr_flags clears ovf/unf at the edge. If a set event occurs in the same cycle, set wins.
- ResetPC with call: push still occurs; PC <= 0.
- ResetPC with ret: ResetPC wins for Address; the pop still occurs (or unf is set if empty).
- stack_full, stack_empty and depth are registered-state decodes; they are valid the cycle after the causing edge.

Optional Feature:
- Macro RAS_WRAP_EN.
- Defined: RAS is circular. A push when full overwrites the oldest entry, depth stays DEPTH, and ovf is set.
- Undefined: a push when full is discarded, stack contents and depth are unchanged, and ovf is set.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then PCplus1+PCenable for 3 cycles -> PCout 0,1,2,3; Address tracks PC+1 each cycle; depth=0, stack_empty=1.
- PC=0x0010, Iside=0xFE, SIGNED_IMM=1, PCplusI -> Address=0x000E. Same with SIGNED_IMM=0 -> Address=0x010E. Rside=0xFFFF, Iside=0x02, RplusI -> Address=0x0001.
- PC=0x0100, call+PCplusI with Iside=0x20 -> PC=0x0120, depth=1. Then ret -> Address=0x0101, next PC=0x0101, depth=0.
- 9 calls at DEPTH=8:
  - RAS_WRAP_EN undefined: ovf=1, depth=8; 8 rets return pushes 8..1 in order, and a 9th ret sets unf with Address=PC+1.
  - RAS_WRAP_EN defined: 8 rets return pushes 9..2 in order.
- Same-cycle call+ret with top=0x0200, PC=0x0300 -> Address=0x0200, depth unchanged, new top=0x0301. Same requests with PCenable=0 -> no state change.
- Reset asserted mid-sequence with depth=5, ovf=1 -> next cycle PC=0, depth=0, ovf=0, Address=0 during reset. clr_flags coinciding with an underflow keeps unf=1.

Source files
------------

// File: rtl/addr_unit_ras.sv
// addr_unit_ras: SAYEH-style addressing unit with a program counter,
// combinational address generation and a hardware return-address stack.
// Optional build macro RAS_WRAP_EN: when defined the stack is circular and a
// push while full overwrites the oldest entry; when undefined such a push is
// dropped. A push while full sets ovf in both builds.
module addr_unit_ras #(
    parameter int AW         = 16,
    parameter int IW         = 8,
    parameter int SIGNED_IMM = 1,
    parameter int DEPTH      = 8,
    parameter int DW         = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] Rside,
    input  logic [IW-1:0] Iside,
    input  logic          ResetPC,
    input  logic          PCplusI,
    input  logic          PCplus1,
    input  logic          RplusI,
    input  logic          Rplus0,
    input  logic          PCenable,
    input  logic          call,
    input  logic          ret,
    input  logic          clr_flags,
    output logic [AW-1:0] Address,
    output logic [AW-1:0] PCout,
    output logic [DW-1:0] depth,
    output logic          stack_full,
    output logic          stack_empty,
    output logic          ovf,
    output logic          unf
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] r_ras [DEPTH];
    logic [PW-1:0] r_sp;      // next free slot; top of stack is r_sp-1
    logic [DW-1:0] r_depth;
    logic [AW-1:0] r_pc;
    logic          r_ovf;
    logic          r_unf;

    logic [AW-1:0] w_imm_ext;
    logic [AW-1:0] w_pc_inc;
    logic [AW-1:0] w_top;
    logic [AW-1:0] w_addr;
    logic          w_empty;
    logic          w_full;

    assign w_pc_inc = r_pc + AW'(1);
    assign w_top    = r_ras[r_sp - PW'(1)];
    assign w_empty  = (r_depth == '0);
    assign w_full   = (r_depth == DW'(DEPTH));

    // Immediate extension to address width, sign or zero per SIGNED_IMM.
    always_comb begin
        w_imm_ext = AW'(Iside);
        if ((SIGNED_IMM != 0) && Iside[IW-1]) begin
            w_imm_ext = w_imm_ext | ~(AW'({IW{1'b1}}));
        end
    end

    // Address mux, priority ResetPC > ret > Rplus0 > RplusI > PCplusI > PCplus1.
    always_comb begin
        w_addr = r_pc;
        if (reset || ResetPC) begin
            w_addr = '0;
        end else if (ret) begin
            w_addr = w_empty ? w_pc_inc : w_top;
        end else if (Rplus0) begin
            w_addr = Rside;
        end else if (RplusI) begin
            w_addr = Rside + w_imm_ext;
        end else if (PCplusI) begin
            w_addr = r_pc + w_imm_ext;
        end else if (PCplus1) begin
            w_addr = w_pc_inc;
        end
    end

    // PC, stack and sticky flags; later set assignments override clr_flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= '0;
            r_sp    <= '0;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (clr_flags) begin
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end
            if (PCenable) begin
                r_pc <= w_addr;
                if (call && ret) begin
                    // Replace-top on a tail call; empty stack degrades to a push.
                    if (w_empty) begin
                        r_ras[r_sp] <= w_pc_inc;
                        r_sp        <= r_sp + PW'(1);
                        r_depth     <= r_depth + DW'(1);
                        r_unf       <= 1'b1;
                    end else begin
                        r_ras[r_sp - PW'(1)] <= w_pc_inc;
                    end
                end else if (call) begin
                    if (w_full) begin
                        r_ovf <= 1'b1;
`ifdef RAS_WRAP_EN
                        // When full, r_sp points at the oldest entry.
                        r_ras[r_sp] <= w_pc_inc;
                        r_sp        <= r_sp + PW'(1);
`endif
                    end else begin
                        r_ras[r_sp] <= w_pc_inc;
                        r_sp        <= r_sp + PW'(1);
                        r_depth     <= r_depth + DW'(1);
                    end
                end else if (ret) begin
                    if (w_empty) begin
                        r_unf <= 1'b1;
                    end else begin
                        r_sp    <= r_sp - PW'(1);
                        r_depth <= r_depth - DW'(1);
                    end
                end
            end
        end
    end

    assign Address     = w_addr;
    assign PCout       = r_pc;
    assign depth       = r_depth;
    assign stack_full  = w_full;
    assign stack_empty = w_empty;
    assign ovf         = r_ovf;
    assign unf         = r_unf;

endmodule

// File: tb/tb_addr_unit_ras.sv
// Self-checking bench for addr_unit_ras: a vector table plus hand sequences,
// a behavioural queue-based stack model, and a queue of expected post-edge state.
module tb_addr_unit_ras;

    localparam int AW    = 16;
    localparam int IW    = 8;
    localparam int DEPTH = 8;
    localparam int DW    = 4;

    localparam logic [8:0] C_RPC  = 9'h100;
    localparam logic [8:0] C_RET  = 9'h080;
    localparam logic [8:0] C_RP0  = 9'h040;
    localparam logic [8:0] C_RPI  = 9'h020;
    localparam logic [8:0] C_PCI  = 9'h010;
    localparam logic [8:0] C_PC1  = 9'h008;
    localparam logic [8:0] C_EN   = 9'h004;
    localparam logic [8:0] C_CALL = 9'h002;
    localparam logic [8:0] C_CLR  = 9'h001;

    typedef struct {
        logic [15:0] r;
        logic [7:0]  i;
        logic        rpc, ret, rp0, rpi, pci, pc1, en, call, clr;
        logic [15:0] exp;
        logic        has_exp;
    } vec_t;

    typedef struct {
        logic [15:0] pc;
        logic [3:0]  depth;
        logic        ovf, unf;
    } post_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] Rside;
    logic [IW-1:0] Iside;
    logic          ResetPC, PCplusI, PCplus1, RplusI, Rplus0;
    logic          PCenable, call, ret, clr_flags;
    logic [AW-1:0] Address, PCout;
    logic [DW-1:0] depth;
    logic          stack_full, stack_empty, ovf, unf;
    logic [AW-1:0] z_Address, z_PCout;
    logic [DW-1:0] z_depth;
    logic          z_full, z_empty, z_ovf, z_unf;

    addr_unit_ras #(.AW(AW), .IW(IW), .SIGNED_IMM(1), .DEPTH(DEPTH), .DW(DW)) u_dut (
        .clk(clk), .reset(reset), .Rside(Rside), .Iside(Iside),
        .ResetPC(ResetPC), .PCplusI(PCplusI), .PCplus1(PCplus1),
        .RplusI(RplusI), .Rplus0(Rplus0), .PCenable(PCenable),
        .call(call), .ret(ret), .clr_flags(clr_flags),
        .Address(Address), .PCout(PCout), .depth(depth),
        .stack_full(stack_full), .stack_empty(stack_empty),
        .ovf(ovf), .unf(unf)
    );

    addr_unit_ras #(.AW(AW), .IW(IW), .SIGNED_IMM(0), .DEPTH(DEPTH), .DW(DW)) u_dut_z (
        .clk(clk), .reset(reset), .Rside(Rside), .Iside(Iside),
        .ResetPC(ResetPC), .PCplusI(PCplusI), .PCplus1(PCplus1),
        .RplusI(RplusI), .Rplus0(Rplus0), .PCenable(PCenable),
        .call(call), .ret(ret), .clr_flags(clr_flags),
        .Address(z_Address), .PCout(z_PCout), .depth(z_depth),
        .stack_full(z_full), .stack_empty(z_empty),
        .ovf(z_ovf), .unf(z_unf)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] m_pc;
    logic [15:0] m_stk [$];
    logic        m_ovf, m_unf;
    post_t       sb [$];
    logic [15:0] last_z;
    vec_t        tbl [14];

    function automatic vec_t mk(input logic [15:0] r, input logic [7:0] i,
                                input logic [8:0] c, input logic [15:0] e,
                                input logic he);
        vec_t v;
        v.r = r; v.i = i;
        v.rpc = c[8]; v.ret = c[7]; v.rp0 = c[6]; v.rpi = c[5]; v.pci = c[4];
        v.pc1 = c[3]; v.en = c[2]; v.call = c[1]; v.clr = c[0];
        v.exp = e; v.has_exp = he;
        return v;
    endfunction

    function automatic logic [15:0] m_address(input vec_t v, input bit sgn);
        logic [15:0] e;
        e = sgn ? {{8{v.i[7]}}, v.i} : {8'h00, v.i};
        if (v.rpc) return 16'h0000;
        if (v.ret) return (m_stk.size() == 0) ? m_pc + 16'd1 : m_stk[m_stk.size()-1];
        if (v.rp0) return v.r;
        if (v.rpi) return v.r + e;
        if (v.pci) return m_pc + e;
        if (v.pc1) return m_pc + 16'd1;
        return m_pc;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        Rside = v.r; Iside = v.i;
        ResetPC = v.rpc; ret = v.ret; Rplus0 = v.rp0; RplusI = v.rpi;
        PCplusI = v.pci; PCplus1 = v.pc1; PCenable = v.en; call = v.call;
        clr_flags = v.clr;
    endtask

    task automatic check_post();
        post_t p;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            p = sb.pop_front();
            chk("pc", PCout, p.pc);
            chk("depth", depth, p.depth);
            chk("stack_full", stack_full, p.depth == 4'd8);
            chk("stack_empty", stack_empty, p.depth == 4'd0);
            chk("ovf", ovf, p.ovf);
            chk("unf", unf, p.unf);
        end
    endtask

    task automatic step(input vec_t v);
        logic [15:0] ea, inc;
        logic        so, su;
        post_t       p;
        @(negedge clk);
        reset = 1'b0;
        drive(v);
        #1;
        ea = m_address(v, 1'b1);
        chk("addr_model", Address, ea);
        chk("addr_zext_model", z_Address, m_address(v, 1'b0));
        last_z = z_Address;
        if (v.has_exp) chk("addr_vec", Address, v.exp);
        inc = m_pc + 16'd1;
        so = 1'b0; su = 1'b0;
        if (v.en) begin
            m_pc = ea;
            if (v.call && v.ret) begin
                if (m_stk.size() == 0) begin
                    m_stk.push_back(inc);
                    su = 1'b1;
                end else begin
                    m_stk[m_stk.size()-1] = inc;
                end
            end else if (v.call) begin
                if (m_stk.size() == DEPTH) begin
                    so = 1'b1;
`ifdef RAS_WRAP_EN
                    void'(m_stk.pop_front());
                    m_stk.push_back(inc);
`endif
                end else begin
                    m_stk.push_back(inc);
                end
            end else if (v.ret) begin
                if (m_stk.size() == 0) su = 1'b1;
                else void'(m_stk.pop_back());
            end
        end
        if (v.clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        m_ovf = m_ovf | so;
        m_unf = m_unf | su;
        p.pc = m_pc; p.depth = 4'(m_stk.size()); p.ovf = m_ovf; p.unf = m_unf;
        sb.push_back(p);
        check_post();
    endtask

    task automatic do_reset(input vec_t v);
        post_t p;
        @(negedge clk);
        drive(v);
        reset = 1'b1;
        #1;
        chk("addr_in_reset", Address, 16'h0000);
        m_pc = 16'h0000; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        p.pc = 16'h0000; p.depth = 4'd0; p.ovf = 1'b0; p.unf = 1'b0;
        sb.push_back(p);
        check_post();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        drive(mk(16'h0, 8'h0, 9'h000, 16'h0, 1'b0));
        m_pc = '0; m_ovf = 1'b0; m_unf = 1'b0;

        tbl[0]  = mk(16'h0000, 8'h00, C_PC1 | C_EN, 16'h0001, 1'b1);
        tbl[1]  = mk(16'h0000, 8'h00, C_PC1 | C_EN, 16'h0002, 1'b1);
        tbl[2]  = mk(16'h0000, 8'h00, C_PC1 | C_EN, 16'h0003, 1'b1);
        tbl[3]  = mk(16'h0010, 8'h00, C_RP0 | C_EN, 16'h0010, 1'b1);
        tbl[4]  = mk(16'h0000, 8'hFE, C_PCI, 16'h000E, 1'b1);
        tbl[5]  = mk(16'hFFFF, 8'h02, C_RPI, 16'h0001, 1'b1);
        tbl[6]  = mk(16'h0100, 8'h00, C_RP0 | C_EN, 16'h0100, 1'b1);
        tbl[7]  = mk(16'h0000, 8'h20, C_CALL | C_PCI | C_EN, 16'h0120, 1'b1);
        tbl[8]  = mk(16'h0000, 8'h00, C_RET | C_EN, 16'h0101, 1'b1);
        tbl[9]  = mk(16'h0000, 8'h00, C_RPC | C_EN, 16'h0000, 1'b1);
        tbl[10] = mk(16'h1234, 8'h01, C_RP0 | C_RPI | C_PCI | C_PC1, 16'h1234, 1'b1);
        tbl[11] = mk(16'h1234, 8'h01, C_RPI | C_PCI | C_PC1, 16'h1235, 1'b1);
        tbl[12] = mk(16'h0000, 8'h05, C_PCI | C_PC1, 16'h0005, 1'b1);
        tbl[13] = mk(16'h0000, 8'h00, 9'h000, 16'h0000, 1'b1);

        do_reset(mk(16'h0, 8'h0, 9'h000, 16'h0, 1'b0));
        for (int i = 0; i < 14; i++) step(tbl[i]);

        // Zero-extended immediate on the SIGNED_IMM=0 instance.
        step(mk(16'h0010, 8'h00, C_RP0 | C_EN, 16'h0010, 1'b1));
        step(mk(16'h0000, 8'hFE, C_PCI, 16'h000E, 1'b1));
        chk("zext_imm", last_z, 16'h010E);

        // Nine calls into an 8-deep stack, then drain past empty.
        step(mk(16'h0, 8'h0, C_RPC | C_EN, 16'h0000, 1'b1));
        for (int k = 0; k < 9; k++) step(mk(16'h0, 8'h0, C_CALL | C_PC1 | C_EN, 16'(k + 1), 1'b1));
        for (int k = 0; k < 8; k++) begin
`ifdef RAS_WRAP_EN
            step(mk(16'h0, 8'h0, C_RET | C_EN, 16'(9 - k), 1'b1));
`else
            step(mk(16'h0, 8'h0, C_RET | C_EN, 16'(8 - k), 1'b1));
`endif
        end
`ifdef RAS_WRAP_EN
        step(mk(16'h0, 8'h0, C_RET | C_EN | C_CLR, 16'h0003, 1'b1));
`else
        step(mk(16'h0, 8'h0, C_RET | C_EN | C_CLR, 16'h0002, 1'b1));
`endif
        chk("unf_set_wins", unf, 1'b1);
        step(mk(16'h0, 8'h0, C_CLR, 16'h0, 1'b0));

        // Same-cycle call+ret replacing the top entry.
        step(mk(16'h01FF, 8'h0, C_RP0 | C_EN, 16'h01FF, 1'b1));
        step(mk(16'h0, 8'h0, C_CALL | C_PC1 | C_EN, 16'h0200, 1'b1));
        step(mk(16'h0300, 8'h0, C_RP0 | C_EN, 16'h0300, 1'b1));
        step(mk(16'h0, 8'h0, C_CALL | C_RET, 16'h0200, 1'b1));
        step(mk(16'h0, 8'h0, C_CALL | C_RET | C_EN, 16'h0200, 1'b1));
        step(mk(16'h0, 8'h0, C_RET | C_EN, 16'h0301, 1'b1));
        step(mk(16'h0, 8'h0, C_CALL | C_RET | C_EN, 16'h0302, 1'b1));
        step(mk(16'h0, 8'h0, C_CLR, 16'h0, 1'b0));

        // ResetPC combined with call and ret.
        step(mk(16'h0, 8'h0, C_RPC | C_CALL | C_EN, 16'h0000, 1'b1));
        step(mk(16'h0, 8'h0, C_RPC | C_RET | C_EN, 16'h0000, 1'b1));
        step(mk(16'h0, 8'h0, C_RPC | C_RET | C_EN, 16'h0000, 1'b1));
        step(mk(16'h0, 8'h0, C_RPC | C_RET | C_EN, 16'h0000, 1'b1));

        // Modulo wrap of PC+1.
        step(mk(16'hFFFF, 8'h0, C_RP0 | C_EN, 16'hFFFF, 1'b1));
        step(mk(16'h0, 8'h0, C_PC1 | C_EN, 16'h0000, 1'b1));

        // Reset in the middle of activity with depth=5 and ovf=1.
        step(mk(16'h0, 8'h0, C_CLR, 16'h0, 1'b0));
        for (int k = 0; k < 9; k++) step(mk(16'h0, 8'h0, C_CALL | C_PC1 | C_EN, 16'(k + 1), 1'b1));
        for (int k = 0; k < 3; k++) step(mk(16'h0, 8'h0, C_RET | C_EN, 16'h0, 1'b0));
        chk("pre_reset_depth", depth, 4'd5);
        chk("pre_reset_ovf", ovf, 1'b1);
        do_reset(mk(16'h0, 8'h0, C_CALL | C_PC1 | C_EN, 16'h0, 1'b0));
        step(mk(16'h0, 8'h0, C_PC1 | C_EN, 16'h0001, 1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
